// File: rtl/ila_probe_capture_if.sv
// Readout stream of the ILA probe capture stage.
// The capture block drives the master side; a register bridge or
// UART dumper sits on the slave side and accepts one sample per handshake.
interface ila_probe_capture_if #(
    parameter int DATA_W = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/ila_probe_capture.sv
// ila_probe_capture: trigger-and-capture stage sharing the probe vector of an
// FPGA ILA instance. Samples a window of DEPTH values around a mask/value
// trigger into a circular buffer and drains it oldest-first over a
// valid/ready stream.
// Optional build macro ILA_CAPTURE_TIMESTAMP_EN: each sample carries a
// free-running TS_W-bit timestamp in the upper bits of rd_data.
module ila_probe_capture #(
    parameter int PROBE_W = 16,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TS_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PROBE_W-1:0]   probe_in,
    input  logic                 arm,
    input  logic [PROBE_W-1:0]   trig_mask,
    input  logic [PROBE_W-1:0]   trig_value,
    input  logic [ADDR_W:0]      pre_trig,
    output logic                 armed,
    output logic                 triggered,
    ila_probe_capture_if.master  rd
);

`ifdef ILA_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int DATA_W = PROBE_W + (TS_EN ? TS_W : 0);

    localparam logic [ADDR_W:0]   MAX_PRE  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_READ      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pre_q, pre_d;
    logic [ADDR_W-1:0]   post_q, post_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                armed_q, armed_d;
    logic                triggered_q, triggered_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic [DATA_W-1:0]   buf_mem [DEPTH];

    logic                match_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [ADDR_W-1:0]   p_s;
    logic [ADDR_W-1:0]   q_s;
    logic [DATA_W-1:0]   wr_data_s;

`ifdef ILA_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q, ts_d;

    // Free-running timestamp, advanced every clock regardless of state.
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    // Timestamp register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= {TS_W{1'b0}};
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_data_s = {ts_q, probe_in};
`else
    assign wr_data_s = probe_in;
`endif

    assign match_s = (((probe_in ^ trig_value) & trig_mask) == {PROBE_W{1'b0}});

    // Pre-trigger count is clamped so at least the trigger sample fits.
    always_comb begin
        if (pre_trig > MAX_PRE) begin
            p_s = LAST_IDX;
        end else begin
            p_s = pre_trig[ADDR_W-1:0];
        end
        q_s = LAST_IDX - p_s;
    end

    // Next-state, sampling and readout-handshake logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        rd_cnt_d    = rd_cnt_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_en_s     = 1'b0;
        rd_addr_s   = rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    // The arm-edge sample is the first one written. With
                    // P=0 it is only filler and gets overwritten by the window.
                    wr_en_s = 1'b1;
                    pre_d   = p_s;
                    post_d  = q_s;
                    cnt_d   = ADDR_W'(1);
                    if (p_s <= ADDR_W'(1)) begin
                        state_d = ST_WAIT_TRIG;
                    end else begin
                        state_d = ST_PRE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                wr_en_s = 1'b1;
                if ((cnt_q + ADDR_W'(1)) == pre_q) begin
                    state_d = ST_WAIT_TRIG;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            ST_WAIT_TRIG: begin
                wr_en_s = 1'b1;
                if (match_s) begin
                    cnt_d = {ADDR_W{1'b0}};
                    if (post_q == {ADDR_W{1'b0}}) begin
                        state_d  = ST_READ;
                        rd_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end else begin
                        state_d  = ST_POST;
                    end
                end else begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_POST: begin
                wr_en_s = 1'b1;
                if ((cnt_q + ADDR_W'(1)) == post_q) begin
                    // Oldest sample sits just past the final write.
                    state_d  = ST_READ;
                    rd_ptr_d = wr_ptr_q + ADDR_W'(1);
                    cnt_d    = {ADDR_W{1'b0}};
                end else begin
                    cnt_d    = cnt_q + ADDR_W'(1);
                end
            end
            ST_READ: begin
                if (!rd_valid_q) begin
                    // First READ cycle: RAM output register is being loaded.
                    rd_valid_d = 1'b1;
                    rd_last_d  = 1'b0;
                    rd_cnt_d   = {ADDR_W{1'b0}};
                end else if (rd.rd_ready) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Fetch the next sample in the same cycle it is accepted.
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        rd_addr_s  = rd_ptr_q + ADDR_W'(1);
                        rd_cnt_d   = rd_cnt_q + ADDR_W'(1);
                        rd_last_d  = ((rd_cnt_q + ADDR_W'(1)) == LAST_IDX);
                    end
                end else begin
                    // Stalled: re-reading the same address keeps rd_data stable.
                    rd_addr_s = rd_ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        armed_d     = (state_d == ST_PRE)  || (state_d == ST_WAIT_TRIG);
        triggered_d = (state_d == ST_POST) || (state_d == ST_READ);
    end

    // Control state, pointers, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            cnt_q       <= {ADDR_W{1'b0}};
            pre_q       <= {ADDR_W{1'b0}};
            post_q      <= {ADDR_W{1'b0}};
            rd_cnt_q    <= {ADDR_W{1'b0}};
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
        end
    end

    // Capture buffer write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_mem[wr_ptr_q] <= wr_data_s;
        end
    end

    // Registered read port, only enabled while draining the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else if (state_q == ST_READ) begin
            rd_data_q <= buf_mem[rd_addr_s];
        end
    end

    assign armed       = armed_q;
    assign triggered   = triggered_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;
    assign rd.rd_data  = rd_data_q;

endmodule
